// File: rtl/ez8_loader_pkg.sv
// ez8_loader_pkg
// Shared definitions for the ez8 program loader: loader FSM states, frame
// header byte, and instruction memory address/data widths.
// No ports (package).

package ez8_loader_pkg;

    localparam int          ADDR_W      = 12;
    localparam int          DATA_W      = 16;
    localparam logic [7:0]  HEADER_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_CHECK,
        ST_RELEASE
    } state_t;

    // States in which the loader is willing to take a stream byte.
    function automatic logic state_ready(state_t s);
        return (s != ST_WRITE) && (s != ST_RELEASE);
    endfunction

endpackage

// File: rtl/ez8_loader_release.sv
// ez8_loader_release
// Generates the CPU reset pulse that follows a good load and the load_done
// pulse that marks the moment the CPU may run.
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset
//   start      in   one-cycle strobe: begin a release sequence
//   cpu_reset  out  high for RESET_CYCLES cycles, starting the cycle after start
//   load_done  out  one-cycle pulse, RESET_CYCLES+1 cycles after cpu_reset rises
//   finishing  out  high in the cycle before load_done; the parent uses it to
//                   drop cpu_pause on the same edge load_done rises

module ez8_loader_release #(
    parameter int RESET_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic cpu_reset,
    output logic load_done,
    output logic finishing
);

    logic [3:0] cnt;
    logic       active;

    // Sequence: RESET_CYCLES cycles of cpu_reset, then one cycle with the CPU
    // out of reset but still paused, then load_done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            active    <= 1'b0;
            cpu_reset <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (start) begin
                active    <= 1'b1;
                cpu_reset <= 1'b1;
                cnt       <= 4'(RESET_CYCLES - 1);
            end else if (active && cpu_reset) begin
                if (cnt == 4'd0) begin
                    cpu_reset <= 1'b0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end else if (active) begin
                active    <= 1'b0;
                load_done <= 1'b1;
            end
        end
    end

    assign finishing = active && !cpu_reset;

endmodule

// File: rtl/ez8_prog_loader.sv
// ez8_prog_loader
// Byte-stream program loader for the ez8 CPU. Parses frames
//   A5, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, N x (DATA_HI, DATA_LO) [, CHECKSUM]
// writes each 16-bit word to instruction memory, keeps the CPU paused while
// loading, then pulses the CPU reset and releases pause.
// Build option: EZ8_LOADER_CHECKSUM_EN -- when defined a trailing checksum byte
// is expected and load_error is live; otherwise load_error is tied low.
//   clk              in   clock, rising edge
//   reset            in   synchronous active-low reset
//   in_data          in   stream byte
//   in_valid         in   in_data valid
//   in_ready         out  loader accepts a byte this cycle
//   instr_writeaddr  out  instruction word address
//   instr_writedata  out  instruction word
//   instr_write_en   out  one-cycle write strobe
//   cpu_pause        out  CPU pause
//   cpu_reset        out  CPU reset, active-high
//   load_done        out  one-cycle pulse when the CPU is released
//   load_error       out  sticky checksum failure, cleared by next header

module ez8_prog_loader
    import ez8_loader_pkg::*;
#(
    parameter int RESET_CYCLES     = 4,
    parameter bit HOLD_AFTER_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] instr_writeaddr,
    output logic [DATA_W-1:0] instr_writedata,
    output logic              instr_write_en,
    output logic              cpu_pause,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

    state_t            state, state_nx;
    logic              accept;
    logic              start_release;
    logic              finishing;
    logic [3:0]        addr_hi_nib;
    logic [3:0]        cnt_hi_nib;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] count_in;
    logic [7:0]        data_hi;

    assign accept   = in_valid && in_ready;
    assign count_in = {cnt_hi_nib, in_data};

`ifdef EZ8_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_good;
    logic       load_error_q;

    assign csum_good  = (8'(csum + in_data) == 8'h00);
    assign load_error = load_error_q;
`else
    assign load_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // start_release fires on the accept edge of the frame's final byte so that
    // cpu_reset rises in the very next cycle. Without a checksum the final byte
    // is the last DATA_LO (or CNT_LO for an empty frame); the release counter
    // then runs underneath the WRITE cycle.
    always_comb begin
        state_nx      = state;
        start_release = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && in_data == HEADER_BYTE) state_nx = ST_ADDR_HI;
            end
            ST_ADDR_HI: if (accept) state_nx = ST_ADDR_LO;
            ST_ADDR_LO: if (accept) state_nx = ST_CNT_HI;
            ST_CNT_HI:  if (accept) state_nx = ST_CNT_LO;
            ST_CNT_LO: begin
                if (accept) begin
                    if (count_in == '0) begin
`ifdef EZ8_LOADER_CHECKSUM_EN
                        state_nx = ST_CHECK;
`else
                        state_nx      = ST_RELEASE;
                        start_release = 1'b1;
`endif
                    end else begin
                        state_nx = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: if (accept) state_nx = ST_DATA_LO;
            ST_DATA_LO: begin
                if (accept) begin
                    state_nx = ST_WRITE;
`ifndef EZ8_LOADER_CHECKSUM_EN
                    if (remaining == ADDR_W'(1)) start_release = 1'b1;
`endif
                end
            end
            ST_WRITE: begin
                // remaining was already decremented on the DATA_LO accept
                if (remaining == '0) begin
`ifdef EZ8_LOADER_CHECKSUM_EN
                    state_nx = ST_CHECK;
`else
                    state_nx = ST_RELEASE;
`endif
                end else begin
                    state_nx = ST_DATA_HI;
                end
            end
            ST_CHECK: begin
`ifdef EZ8_LOADER_CHECKSUM_EN
                if (accept) begin
                    if (csum_good) begin
                        state_nx      = ST_RELEASE;
                        start_release = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
`else
                state_nx = ST_IDLE;
`endif
            end
            ST_RELEASE: if (finishing) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_ready        <= 1'b0;
            instr_writeaddr <= '0;
            instr_writedata <= '0;
            instr_write_en  <= 1'b0;
            cpu_pause       <= HOLD_AFTER_RESET;
            addr_hi_nib     <= '0;
            cnt_hi_nib      <= '0;
            addr            <= '0;
            remaining       <= '0;
            data_hi         <= '0;
`ifdef EZ8_LOADER_CHECKSUM_EN
            csum            <= '0;
            load_error_q    <= 1'b0;
`endif
        end else begin
            instr_write_en <= 1'b0;
            in_ready       <= state_ready(state_nx);
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (in_data == HEADER_BYTE) begin
                            cpu_pause    <= 1'b1;
`ifdef EZ8_LOADER_CHECKSUM_EN
                            load_error_q <= 1'b0;
                            csum         <= '0;
`endif
                        end
                    end
                    ST_ADDR_HI: addr_hi_nib <= in_data[3:0];
                    ST_ADDR_LO: addr        <= {addr_hi_nib, in_data};
                    ST_CNT_HI:  cnt_hi_nib  <= in_data[3:0];
                    ST_CNT_LO:  remaining   <= count_in;
                    ST_DATA_HI: begin
                        data_hi <= in_data;
`ifdef EZ8_LOADER_CHECKSUM_EN
                        csum    <= csum + in_data;
`endif
                    end
                    ST_DATA_LO: begin
                        instr_writeaddr <= addr;
                        instr_writedata <= {data_hi, in_data};
                        instr_write_en  <= 1'b1;
                        addr            <= addr + ADDR_W'(1);
                        remaining       <= remaining - ADDR_W'(1);
`ifdef EZ8_LOADER_CHECKSUM_EN
                        csum            <= csum + in_data;
`endif
                    end
`ifdef EZ8_LOADER_CHECKSUM_EN
                    ST_CHECK: if (!csum_good) load_error_q <= 1'b1;
`endif
                    default: ;
                endcase
            end
            if (finishing) cpu_pause <= 1'b0;
        end
    end

    ez8_loader_release #(
        .RESET_CYCLES(RESET_CYCLES)
    ) u_release (
        .clk      (clk),
        .reset    (reset),
        .start    (start_release),
        .cpu_reset(cpu_reset),
        .load_done(load_done),
        .finishing(finishing)
    );

endmodule

// File: tb/tb_ez8_prog_loader.sv
// tb_ez8_prog_loader
// Self-checking bench for ez8_prog_loader. Frames are built from word lists;
// expected writes and release timing come from the frame contents.

module tb_ez8_prog_loader;

    localparam int R = 4;
`ifdef EZ8_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [15:0] word_q_t[$];
    typedef logic [27:0] wr_q_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] instr_writeaddr;
    logic [15:0] instr_writedata;
    logic        instr_write_en;
    logic        cpu_pause;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc, rise_cyc, done_cyc, fall_cyc, rst_hi_cnt, done_cnt, pause_viol;
    logic prev_rst   = 1'b0;
    logic prev_pause = 1'b0;
    wr_q_t obs_q;

    ez8_prog_loader #(.RESET_CYCLES(R), .HOLD_AFTER_RESET(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instr_writeaddr(instr_writeaddr),
        .instr_writedata(instr_writedata),
        .instr_write_en (instr_write_en),
        .cpu_pause      (cpu_pause),
        .cpu_reset      (cpu_reset),
        .load_done      (load_done),
        .load_error     (load_error)
    );

    always #5 clk = ~clk;

    // Observe outputs 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (instr_write_en) begin
                obs_q.push_back({instr_writeaddr, instr_writedata});
                if (!cpu_pause) pause_viol++;
            end
            if (cpu_reset && !prev_rst) rise_cyc = cyc;
            if (cpu_reset) rst_hi_cnt++;
            if (load_done) begin done_cyc = cyc; done_cnt++; end
            if (prev_pause && !cpu_pause) fall_cyc = cyc;
            prev_rst   = cpu_reset;
            prev_pause = cpu_pause;
        end
    end

    function automatic void clear_obs();
        obs_q.delete();
        rise_cyc = -1; done_cyc = -1; fall_cyc = -1;
        rst_hi_cnt = 0; done_cnt = 0; pause_viol = 0;
    endfunction

    function automatic byte_q_t build_frame(input logic [11:0] a, input word_q_t w,
                                            input logic [7:0] cs_delta, input bit junk);
        byte_q_t     f;
        logic [7:0]  sum = 8'h00;
        logic [11:0] n = 12'(w.size());
        f.push_back(8'hA5);
        f.push_back({junk ? 4'($urandom_range(0, 15)) : 4'h0, a[11:8]});
        f.push_back(a[7:0]);
        f.push_back({junk ? 4'($urandom_range(0, 15)) : 4'h0, n[11:8]});
        f.push_back(n[7:0]);
        foreach (w[i]) begin
            f.push_back(w[i][15:8]);
            f.push_back(w[i][7:0]);
            sum = sum + w[i][15:8] + w[i][7:0];
        end
        if (CS) f.push_back(8'(8'h00 - sum + cs_delta));
        return f;
    endfunction

    function automatic wr_q_t model_writes(input logic [11:0] a, input word_q_t w);
        wr_q_t q;
        foreach (w[i]) q.push_back({12'(a + i), w[i]});
        return q;
    endfunction

    // Drives bytes at #1 after an edge; a byte transfers at the next edge when
    // valid and ready are both high. Ends #1 after an edge.
    task automatic send_bytes(input byte_q_t b, input bit toggle);
        bit ph = 1'b0;
        foreach (b[i]) begin
            int waited = 0;
            bit done = 1'b0;
            while (!done) begin
                in_data  = b[i];
                in_valid = toggle ? ph : 1'b1;
                ph       = ~ph;
                done     = in_valid && in_ready;
                if (done) last_acc = cyc + 1;
                @(posedge clk); #1;
                if (!done) begin
                    waited++;
                    if (waited > 64) begin
                        n_checks++; n_fail++;
                        $display("FAIL send_timeout: byte %0d (%h) not accepted within 64 cycles", i, b[i]);
                        done = 1'b1;
                    end
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (R + 12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (instr_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", instr_write_en); end
        n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_reset: got %b want 0", cpu_reset); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %b want 0", load_done); end
        n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL reset_load_error: got %b want 0", load_error); end
        n_checks++; if (instr_writeaddr !== 12'h000) begin n_fail++; $display("FAIL reset_addr: got %h want 000", instr_writeaddr); end
        n_checks++; if (instr_writedata !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", instr_writedata); end
        n_checks++; if (cpu_pause !== 1'b1) begin n_fail++; $display("FAIL reset_pause: got %b want 1", cpu_pause); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic_frame();
        word_q_t w = '{16'h1234, 16'hABCD};
        wr_q_t   e = model_writes(12'h110, w);
        clear_obs();
        send_bytes(build_frame(12'h110, w, 8'h00, 1'b0), 1'b0);
        settle();
        n_checks++; if (obs_q.size() !== e.size()) begin n_fail++; $display("FAIL basic_nwrites: got %0d want %0d", obs_q.size(), e.size()); end
        foreach (e[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== e[i]) begin n_fail++; $display("FAIL basic_write%0d: got %h want %h", i, obs_q[i], e[i]); end
        end
        n_checks++; if (rise_cyc !== last_acc) begin n_fail++; $display("FAIL basic_reset_rise: got cycle %0d want %0d", rise_cyc, last_acc); end
        n_checks++; if (rst_hi_cnt !== R) begin n_fail++; $display("FAIL basic_reset_len: got %0d want %0d", rst_hi_cnt, R); end
        n_checks++; if (done_cyc !== rise_cyc + R + 1) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, rise_cyc + R + 1); end
        n_checks++; if (fall_cyc !== done_cyc) begin n_fail++; $display("FAIL basic_pause_fall: got %0d want %0d", fall_cyc, done_cyc); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        n_checks++; if (pause_viol !== 0) begin n_fail++; $display("FAIL basic_pause_on_write: got %0d unpaused writes want 0", pause_viol); end
        n_checks++; if (cpu_pause !== 1'b0) begin n_fail++; $display("FAIL basic_pause_end: got %b want 0", cpu_pause); end
    endtask

    task automatic test_wrap();
        word_q_t w = '{16'($urandom), 16'($urandom)};
        wr_q_t   e = model_writes(12'hFFF, w);
        clear_obs();
        send_bytes(build_frame(12'hFFF, w, 8'h00, 1'b0), 1'b0);
        settle();
        n_checks++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL wrap_nwrites: got %0d want 2", obs_q.size()); end
        foreach (e[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== e[i]) begin n_fail++; $display("FAIL wrap_write%0d: got %h want %h", i, obs_q[i], e[i]); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL wrap_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_count();
        word_q_t w;
        clear_obs();
        send_bytes(build_frame(12'h234, w, 8'h00, 1'b0), 1'b0);
        settle();
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL zero_nwrites: got %0d want 0", obs_q.size()); end
        n_checks++; if (rise_cyc !== last_acc) begin n_fail++; $display("FAIL zero_reset_rise: got %0d want %0d", rise_cyc, last_acc); end
        n_checks++; if (rst_hi_cnt !== R) begin n_fail++; $display("FAIL zero_reset_len: got %0d want %0d", rst_hi_cnt, R); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_checksum_error();
        word_q_t w = '{16'h1234, 16'hABCD};
        byte_q_t f = build_frame(12'h110, w, 8'h01, 1'b0);
        clear_obs();
`ifndef EZ8_LOADER_CHECKSUM_EN
        f.push_back(8'h43);  // stray trailing byte, dropped in IDLE
`endif
        send_bytes(f, 1'b0);
        settle();
        n_checks++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL err_nwrites: got %0d want 2", obs_q.size()); end
`ifdef EZ8_LOADER_CHECKSUM_EN
        n_checks++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", load_error); end
        n_checks++; if (cpu_pause !== 1'b1) begin n_fail++; $display("FAIL err_pause: got %b want 1", cpu_pause); end
        n_checks++; if (rst_hi_cnt !== 0) begin n_fail++; $display("FAIL err_no_reset: got %0d reset cycles want 0", rst_hi_cnt); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL err_no_done: got %0d want 0", done_cnt); end
        clear_obs();
        send_bytes(build_frame(12'h110, w, 8'h00, 1'b0), 1'b0);
        settle();
        n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", load_error); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL err_recover_done: got %0d want 1", done_cnt); end
`else
        n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL err_tied_low: got %b want 0", load_error); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL err_done_cnt: got %0d want 1", done_cnt); end
`endif
    endtask

    task automatic test_throttled_garbage();
        word_q_t w = '{16'h1234, 16'hABCD};
        wr_q_t   e = model_writes(12'h110, w);
        byte_q_t f = '{8'h00, 8'hFF};
        byte_q_t g = build_frame(12'h110, w, 8'h00, 1'b0);
        foreach (g[i]) f.push_back(g[i]);
        clear_obs();
        send_bytes(f, 1'b1);
        settle();
        n_checks++; if (obs_q.size() !== e.size()) begin n_fail++; $display("FAIL thr_nwrites: got %0d want %0d", obs_q.size(), e.size()); end
        foreach (e[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== e[i]) begin n_fail++; $display("FAIL thr_write%0d: got %h want %h", i, obs_q[i], e[i]); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL thr_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_mid_reset();
        word_q_t w = '{16'h1234, 16'hABCD};
        wr_q_t   e = model_writes(12'h110, w);
        byte_q_t f = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        clear_obs();
        send_bytes(f, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL mid_partial_writes: got %0d want 1", obs_q.size()); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        n_checks++; if (instr_writeaddr !== 12'h000) begin n_fail++; $display("FAIL mid_addr: got %h want 000", instr_writeaddr); end
        n_checks++; if (instr_writedata !== 16'h0000) begin n_fail++; $display("FAIL mid_data: got %h want 0000", instr_writedata); end
        n_checks++; if (cpu_pause !== 1'b1) begin n_fail++; $display("FAIL mid_pause: got %b want 1", cpu_pause); end
        n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL mid_cpu_reset: got %b want 0", cpu_reset); end
        reset = 1'b1;
        @(posedge clk); #1;
        clear_obs();
        send_bytes(build_frame(12'h110, w, 8'h00, 1'b0), 1'b0);
        settle();
        n_checks++; if (obs_q.size() !== e.size()) begin n_fail++; $display("FAIL mid_nwrites: got %0d want %0d", obs_q.size(), e.size()); end
        foreach (e[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== e[i]) begin n_fail++; $display("FAIL mid_write%0d: got %h want %h", i, obs_q[i], e[i]); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL mid_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            word_q_t     w;
            byte_q_t     f;
            byte_q_t     g;
            wr_q_t       e;
            logic [11:0] a = ($urandom_range(0, 2) == 0) ? 12'(12'hFFE - $urandom_range(0, 2)) : 12'($urandom);
            int          n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) w.push_back(16'($urandom));
            for (int k = 0; k < $urandom_range(0, 2); k++) begin
                logic [7:0] j = 8'($urandom);
                f.push_back((j == 8'hA5) ? 8'h5A : j);
            end
            g = build_frame(a, w, 8'h00, 1'b1);
            foreach (g[i]) f.push_back(g[i]);
            e = model_writes(a, w);
            clear_obs();
            send_bytes(f, 1'($urandom_range(0, 1)));
            settle();
            n_checks++; if (obs_q.size() !== e.size()) begin n_fail++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", it, obs_q.size(), e.size()); end
            foreach (e[i]) if (i < obs_q.size()) begin
                n_checks++; if (obs_q[i] !== e[i]) begin n_fail++; $display("FAIL rnd%0d_write%0d: got %h want %h", it, i, obs_q[i], e[i]); end
            end
            n_checks++; if (rise_cyc !== last_acc) begin n_fail++; $display("FAIL rnd%0d_reset_rise: got %0d want %0d", it, rise_cyc, last_acc); end
            n_checks++; if (done_cyc !== last_acc + R + 1) begin n_fail++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", it, done_cyc, last_acc + R + 1); end
            n_checks++; if (pause_viol !== 0) begin n_fail++; $display("FAIL rnd%0d_pause_on_write: got %0d want 0", it, pause_viol); end
        end
    endtask

    task automatic test_back_to_back();
        word_q_t w1 = '{16'hCAFE, 16'hA5A5, 16'h00A5};
        word_q_t w2 = '{16'h5555};
        wr_q_t   e  = model_writes(12'h7F0, w1);
        wr_q_t   e2 = model_writes(12'h003, w2);
        byte_q_t f  = build_frame(12'h7F0, w1, 8'h00, 1'b0);
        byte_q_t g  = build_frame(12'h003, w2, 8'h00, 1'b0);
        foreach (g[i]) f.push_back(g[i]);
        foreach (e2[i]) e.push_back(e2[i]);
        clear_obs();
        send_bytes(f, 1'b0);
        settle();
        n_checks++; if (obs_q.size() !== e.size()) begin n_fail++; $display("FAIL b2b_nwrites: got %0d want %0d", obs_q.size(), e.size()); end
        foreach (e[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== e[i]) begin n_fail++; $display("FAIL b2b_write%0d: got %h want %h", i, obs_q[i], e[i]); end
        end
        n_checks++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); end
        n_checks++; if (rst_hi_cnt !== 2 * R) begin n_fail++; $display("FAIL b2b_reset_len: got %0d want %0d", rst_hi_cnt, 2 * R); end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_basic_frame();
        test_wrap();
        test_zero_count();
        test_checksum_error();
        test_throttled_garbage();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ez8_prog_loader.md
# ez8_prog_loader

Byte-stream program loader sitting directly upstream of the ez8 CPU core. Accepts framed bytes over a valid/ready interface, assembles 16-bit instruction words, writes them into instruction memory through the CPU's `instr_write*` port, and holds the CPU paused during loading. After a good frame it issues a reset pulse to the CPU and then releases pause.

## Interface
- `RESET_CYCLES`, default 4: cycles `cpu_reset` is held high after a successful load; legal range 1..15.
- `HOLD_AFTER_RESET`, default 1: when 1, `cpu_pause` is 1 out of reset until the first successful load; when 0, it is 0 out of reset.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `instr_writeaddr`  out  12  instruction memory word address.
- `instr_writedata`  out  16  instruction word.
- `instr_write_en`  out  1  one-cycle write strobe.
- `cpu_pause`  out  1  drives the CPU `pause` input.
- `cpu_reset`  out  1  drives the CPU `reset` input, active-high.
- `load_done`  out  1  one-cycle pulse on release.
- `load_error`  out  1  sticky; set on a checksum failure, cleared at the next header byte.

## Operation
- A byte transfers when `in_valid && in_ready` at a rising edge.
- Frame layout: header 0xA5, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, N×(DATA_HI, DATA_LO), then [CHECKSUM].
  - Address is `{ADDR_HI[3:0], ADDR_LO}`; upper nibble ignored.
  - Count N is `{CNT_HI[3:0], CNT_LO}`, range 0..4095.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHECK, RELEASE.
- IDLE:
  - Non-0xA5 bytes are consumed and dropped.
  - 0xA5 sets `cpu_pause`=1, clears `load_error` and the checksum accumulator, then moves to ADDR_HI.
- Header fields are consumed in order.
  - After CNT_LO, N=0 goes directly to CHECK (or RELEASE when checksum is compiled out).
  - Otherwise go to DATA_HI.
- DATA_LO accept → WRITE:
  - `instr_write_en`=1 for exactly one cycle.
  - Address is the current word address; data is `{hi, lo}`.
  - After the write, the address increments modulo 4096 (0xFFF wraps to 0x000) and the remaining count decrements.
  - If the count reaches 0, next state is CHECK/RELEASE; else DATA_HI.
- Checksum: 8-bit sum of all data bytes plus the checksum byte. Good when the sum is 0x00.
  - Good → RELEASE.
  - Bad → `load_error`=1, `cpu_pause` stays 1, `cpu_reset` is not pulsed, return to IDLE.
- RELEASE:
  - `cpu_reset`=1 and `cpu_pause`=1 for RESET_CYCLES cycles.
  - Then `cpu_pause`=0, `load_done`=1 for one cycle, return to IDLE.
- A 0xA5 arriving mid-frame is data, never a resync.
- Reset mid-operation aborts the frame. Already-written words stay in memory.

## Timing
- Values after `reset`=0:
  - state IDLE.
  - `instr_write_en`, `cpu_reset`, `load_done`, `load_error` = 0.
  - `instr_writeaddr`, `instr_writedata` = 0.
  - `cpu_pause` = HOLD_AFTER_RESET.
- `in_ready`:
  - 1 in IDLE, the header states, DATA_HI, DATA_LO and CHECK.
  - 0 in WRITE and RELEASE, and while `reset`=0.
- All outputs are registered.
- `instr_write_en` rises the cycle after the DATA_LO accept, so write throughput is at most one word per 3 cycles.
- Last byte accept → `cpu_reset` rises the next cycle.
- `cpu_pause` falls RESET_CYCLES+1 cycles after `cpu_reset` rises, coincident with `load_done`.
- `cpu_pause` is 1 in every cycle where `instr_write_en`=1.

## Configuration
- `EZ8_LOADER_CHECKSUM_EN`:
  - Defined: CHECKSUM byte expected; CHECK state and `load_error` logic are present.
  - Undefined: no checksum byte; after the last write go straight to RELEASE; `load_error` is tied to 0.

## Structure
- Shared package `ez8_loader_pkg` holds:
  - state enum;
  - header constant 0xA5;
  - address width 12;
  - data width 16.
- Sub-module `ez8_loader_release`: counter for the RESET_CYCLES pulse plus `load_done` generation, started by a one-cycle start strobe.

## Test plan
- Frame A5 01 10 00 02 12 34 AB CD [checksum 0x42] → writes 0x1234@0x110, then 0xABCD@0x111; `cpu_reset` high 4 cycles; `cpu_pause` falls with `load_done`.
- Address 0x0FFF, N=2 → writes at 0xFFF then 0x000 (wrap).
- Bad checksum (0x43 in frame 1) → both writes occur, `load_error`=1, `cpu_pause` stays 1, no `cpu_reset`; a following good frame clears the error.
- N=0 frame, checksum 0x00 → no `instr_write_en`, normal release.
- `in_valid` toggling every other cycle plus garbage bytes 0x00/0xFF before the header → garbage ignored, same writes as frame 1.
- `reset`=0 asserted after 3 data bytes → outputs at reset values the next cycle; a following full frame loads correctly.
